// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bus of the write-port arbiter.
// The master modport is the arbiter's view; the slave modport is the view of the producers and the FIFO.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int IDX_W      = 2
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            ack;
   logic                          fifo_full;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_data;
   logic [IDX_W-1:0]              grant_idx;
   logic                          busy;

   modport master (
      input  req, req_data, fifo_full,
      output ack, fifo_wr_en, fifo_data, grant_idx, busy
   );

   modport slave (
      output req, req_data, fifo_full,
      input  ack, fifo_wr_en, fifo_data, grant_idx, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Each grant lasts for a burst of up to MAX_BURST words.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int IDX_W      = 2,
   parameter int MAX_BURST  = 4,
   parameter int BURST_W    = 3
) (
   input  logic               clk,
   input  logic               rst,
   fifo_wr_arbiter_if.master  bus
);
   typedef enum logic {IDLE, GRANT} state_t;

   state_t                state, state_nxt;
   logic [IDX_W-1:0]      owner, owner_nxt, rr_ptr, rr_ptr_nxt;
   logic [IDX_W-1:0]      sel_idx, owner_inc;
   logic [BURST_W-1:0]    burst_cnt, burst_cnt_nxt;
   logic                  sel_vld, owner_req, accept;
   logic [DATA_WIDTH-1:0] owner_data;
   int                    cand;

   // Cyclic scan starting at rr_ptr; explicit wrap keeps non-power-of-two NUM_REQ correct.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      cand    = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(rr_ptr) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!sel_vld && bus.req[IDX_W'(cand)]) begin
            sel_vld = 1'b1;
            sel_idx = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      owner_req  = 1'b0;
      owner_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner == IDX_W'(i)) begin
            owner_req  = bus.req[i];
            owner_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign owner_inc = (owner == IDX_W'(NUM_REQ-1)) ? '0 : owner + 1'b1;

   // Reset cycle suppresses the write so an interrupted burst never leaks a word.
   assign accept = (state == GRANT) && owner_req && !bus.fifo_full && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         rr_ptr    <= rr_ptr_nxt;
         burst_cnt <= burst_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      owner_nxt     = owner;
      rr_ptr_nxt    = rr_ptr;
      burst_cnt_nxt = burst_cnt;
      case (state)
         IDLE: begin
            if (sel_vld) begin
               owner_nxt     = sel_idx;
               burst_cnt_nxt = '0;
               state_nxt     = GRANT;
            end
         end
         GRANT: begin
            if (!owner_req) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = owner_inc;
            end else if (accept) begin
               if (burst_cnt == BURST_W'(MAX_BURST-1)) begin
                  state_nxt  = IDLE;
                  rr_ptr_nxt = owner_inc;
               end else begin
                  burst_cnt_nxt = burst_cnt + 1'b1;
               end
            end
            // full with req held: stall, everything holds
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.ack = '0;
      for (int i = 0; i < NUM_REQ; i++)
         bus.ack[i] = accept && (owner == IDX_W'(i));
   end

   assign bus.fifo_wr_en = accept;
   assign bus.fifo_data  = accept ? owner_data : '0;
   assign bus.grant_idx  = rst ? '0 : owner;
   assign bus.busy       = (state == GRANT) && !rst;
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that lets NUM_REQ producers share the single write port of one fifoArray instance in the butterfly datapath.
- Grants one requester at a time for a burst of up to MAX_BURST words.
- Drives the FIFO's write enable and data, and back-pressures all producers while the FIFO reports full.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_WIDTH, 8, word width; matches the FIFO data bus.
- IDX_W, 2, width of requester index (ceil(log2(NUM_REQ))).
- MAX_BURST, 4, maximum words written per grant (≥1).
- BURST_W, 3, burst counter width (holds 0..MAX_BURST-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester write request; bit i = requester i.
- req_data  input  NUM_REQ*DATA_WIDTH  requester i word in bits [i*DATA_WIDTH +: DATA_WIDTH].
- ack  output  NUM_REQ  one-hot pulse: word of requester i accepted this cycle.
- fifo_full  input  1  full flag from the FIFO.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_data  output  DATA_WIDTH  FIFO write data.
- grant_idx  output  IDX_W  current/last owner index.
- busy  output  1  high while in GRANT.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high, sampled on the rising edge.
- Registered state: state (IDLE/GRANT), owner, rr_ptr, burst_cnt.
- Reset values: state=IDLE, owner=0, rr_ptr=0, burst_cnt=0.
- Output values in and immediately after reset: ack=0, fifo_wr_en=0, fifo_data=0, grant_idx=0, busy=0.
- Reset mid-burst: abandons the burst with no write in the reset cycle; the partial burst is not resumed.
- Requester protocol:
  - Requester raises req with valid req_data and holds both stable until its ack.
  - Requester may drop req in any cycle without ack.
  - A word is transferred exactly in the cycle ack is high.
- IDLE state:
  - No writes.
  - If any req bit is set, select the first set bit scanning cyclically from rr_ptr (rr_ptr, rr_ptr+1, … wrapping at NUM_REQ).
  - On selection: owner<=selected index, burst_cnt<=0, state<=GRANT.
  - Otherwise remain in IDLE.
- GRANT state (combinational from registered state and inputs):
  - accept = req[owner] & ~fifo_full.
  - fifo_wr_en = accept.
  - ack = accept << owner.
  - fifo_data = req_data word of owner when accept, else 0.
- GRANT transitions:
  - accept and burst_cnt==MAX_BURST-1: write, then state<=IDLE, rr_ptr<=(owner+1) mod NUM_REQ.
  - accept otherwise: burst_cnt<=burst_cnt+1, stay in GRANT.
  - req[owner]==0: no write, state<=IDLE, rr_ptr<=(owner+1) mod NUM_REQ (release on drop).
  - req[owner]==1 and fifo_full==1: stall. No write, no ack, owner and burst_cnt held; no timeout.
- Derived outputs:
  - busy = (state==GRANT).
  - grant_idx = owner at all times.
- Latency:
  - Zero cycles from ack to FIFO write.
  - One arbitration cycle (IDLE) between consecutive grants.
  - Sustained throughput with continuous requests: MAX_BURST words per MAX_BURST+1 cycles.
- Fairness:
  - rr_ptr advances only on release.
  - A sole requester is re-granted after the IDLE cycle.
  - No requester is skipped while requesting.
- Width and wrap rules:
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Index arithmetic is modulo NUM_REQ even when NUM_REQ is not a power of two.
- fifo_full is honoured in the same cycle; no write is ever issued while fifo_full=1.
- Simultaneous events:
  - req changes on non-owner bits during GRANT are ignored until the next IDLE.
  - Final burst word together with fifo_full=1 counts as a stall, not a release.

Test Plan:
1. Hold rst=1 for 2 cycles with req=4'b1111 → ack=0, fifo_wr_en=0, busy=0, grant_idx=0. After release: IDLE for 1 cycle, then GRANT with owner 0, first write in the 2nd cycle after reset deassert.
2. Only req[2] high with words 0x10..0x15 (advance on ack) → writes 0x10,0x11,0x12,0x13 on 4 consecutive cycles with ack=4'b0100. One cycle with wr_en=0, then re-grant to 2. Writes 0x14,0x15, then drop req → release, rr_ptr=3.
3. req=4'b1111 continuously, each requester's data = 0xA0+index → grant order 0,1,2,3,0, 4 words each, 1 idle cycle between grants. Exactly 16 writes in the first 20 GRANT/IDLE cycles.
4. Owner 1 mid-burst after 2 words, fifo_full=1 for 3 cycles → fifo_wr_en=0 and ack=0 for those 3 cycles, grant_idx stays 1. Burst resumes with 2 further writes, then release.
5. Owner 3 drops req after 1 word while req[0] is high → 1 GRANT cycle with no write, IDLE cycle, grant to 0 (rr_ptr wrapped from 3 to 0).
6. Assert rst for 1 cycle during owner 2's 3rd word → no write that cycle, busy=0 next cycle, rr_ptr=0. With req=4'b0110, the next grant goes to 1.
